sakebi_ethernet_tx_arbiter: RTL
===============================

SAKEBI_ETHERNET_TX_ARBITER -- requirements
Module: sakebi_ethernet_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte-lane width of all TDATA buses.
REQ-002 i_axis_ACLK  input  1  clock; all logic on its rising edge.
REQ-003 i_axis_ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 i_axis0_TVALID / i_axis1_TVALID  input  1 each  requester 0 (ARP) / requester 1 (IPv4) data valid.
REQ-005 o_axis0_TREADY / o_axis1_TREADY  output  1 each  per-requester ready.
REQ-006 i_axis0_TDATA / i_axis1_TDATA  input  DATA_WIDTH each  per-requester payload byte.
REQ-007 i_axis0_TLAST / i_axis1_TLAST  input  1 each  last byte of the requester's frame.
REQ-008 i_ethertype0 / i_ethertype1  input  DATA_WIDTH*2 each  requested EtherType, valid while TVALID high.
REQ-009 i_dst_mac0 / i_dst_mac1  input  DATA_WIDTH*6 each  requested destination MAC, valid while TVALID high.
REQ-010 o_axis_TVALID  output  1  merged stream valid.
REQ-011 i_axis_TREADY  input  1  downstream frame-TX ready.
REQ-012 o_axis_TDATA  output  DATA_WIDTH  merged payload byte.
REQ-013 o_axis_TLAST  output  1  merged last byte.
REQ-014 o_ethertype  output  DATA_WIDTH*2  EtherType latched for the current frame.
REQ-015 o_dst_mac_addr  output  DATA_WIDTH*6  destination MAC latched for the current frame.
REQ-016 o_grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-017 o_abort  output  1  one-cycle pulse on watchdog abort (0 when macro absent).

Function
REQ-018 FSM states IDLE, GRANT0, GRANT1; exactly one active.
REQ-019 IDLE: no TVALID -> stay; one TVALID -> GRANTn next cycle; both -> grant the requester not served last (round-robin pointer).
REQ-020 On IDLE->GRANTn, o_ethertype and o_dst_mac_addr SHALL register requester n's sideband and hold it unchanged until the next grant.
REQ-021 In GRANTn: o_axis_TVALID/TDATA/TLAST = requester n's (combinational mux); o_axisn_TREADY = i_axis_TREADY; other requester's TREADY = 0.
REQ-022 In IDLE both o_axisn_TREADY = 0 and o_axis_TVALID = 0; arbitration latency is exactly 1 cycle from TVALID to first transferable beat.
REQ-023 Grant released only on a beat with TVALID & TREADY & TLAST: next state IDLE, pointer = n; at least one idle cycle between frames.
REQ-024 Mid-frame TVALID drops by the owner or TREADY stalls downstream SHALL NOT release the grant.
REQ-025 A TLAST beat not accepted (TREADY=0) SHALL keep the grant until accepted.
REQ-026 Single-beat frames (TLAST on first beat) SHALL be legal: GRANTn for one accepted beat, then IDLE.
REQ-027 A requester asserting TVALID during the other's grant SHALL wait and win the next arbitration if still valid.

Reset
REQ-028 While i_axis_ARESETn low: state IDLE, pointer = 1 (requester 0 wins first tie), o_grant = 0, o_ethertype = 0, o_dst_mac_addr = 0, o_abort = 0, all TREADY/TVALID = 0; mid-frame reset drops the frame with no TLAST emitted.

Configuration
REQ-029 Macro SAKEBI_TX_ARB_WATCHDOG_EN defined: 8-bit counter counts cycles in GRANTn with owner TVALID low, clears on any owner TVALID-high cycle; at 255 consecutive such cycles FSM -> IDLE, pointer = n, o_abort pulses one cycle, no TLAST emitted.
REQ-030 Macro absent: no counter, o_abort tied 0, grant held indefinitely.

Verification
REQ-031 Only axis0 sends 4-byte frame 0x11..0x14, EtherType 0x0806 -> o_grant=01 one cycle later, 4 beats out in order, o_ethertype=0x0806, IDLE after TLAST.
REQ-032 Both valid from reset, axis1 EtherType 0x0800 -> axis0 frame first, then axis1 frame, o_ethertype switches 0x0806->0x0800 only at second grant.
REQ-033 axis1 frame with i_axis_TREADY low 3 cycles on TLAST beat -> TLAST held, grant kept, axis0 TREADY stays 0.
REQ-034 Single-beat frame 0xAA on axis1 -> one output beat with TLAST=1, IDLE next cycle.
REQ-035 Reset asserted mid-frame after 2 beats -> all outputs reset values asynchronously, next frame arbitrates from pointer=1.
REQ-036 SAKEBI_TX_ARB_WATCHDOG_EN defined, owner TVALID low 255 cycles mid-frame -> o_abort one-cycle pulse, o_grant=00; 254 cycles -> no abort.

Source files
------------

// File: rtl/sakebi_ethernet_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sakebi_ethernet_tx_arbiter
//
// Purpose: merges two AXI-Stream frame sources (requester 0 = ARP, requester
// 1 = IPv4) onto a single frame-TX stream. Arbitration happens between frames
// only: once a requester is granted it owns the output until its TLAST beat is
// accepted. Ties are broken round-robin (the requester not served last wins).
// The EtherType and destination MAC of the granted requester are latched at
// grant time and held until the next grant.
//
// Ports:
//   i_axis_ACLK, i_axis_ARESETn         clock, asynchronous active-low reset
//   i_axis{0,1}_TVALID/TDATA/TLAST      requester streams
//   o_axis{0,1}_TREADY                  per-requester ready (only owner sees it)
//   i_ethertype{0,1}, i_dst_mac{0,1}    per-requester sideband, valid with TVALID
//   o_axis_TVALID/TDATA/TLAST           merged stream
//   i_axis_TREADY                       downstream ready
//   o_ethertype, o_dst_mac_addr         sideband latched for the current frame
//   o_grant                             one-hot owner, 2'b00 when idle
//   o_abort                             one-cycle pulse on watchdog abort
//
// Optional feature: define SAKEBI_TX_ARB_WATCHDOG_EN to enable the stalled
// owner watchdog (255 consecutive owner-TVALID-low cycles abort the frame).
// Without it o_abort is tied low and a grant is held indefinitely.
// -----------------------------------------------------------------------------
module sakebi_ethernet_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      i_axis_ACLK,
  input  logic                      i_axis_ARESETn,
  input  logic                      i_axis0_TVALID,
  output logic                      o_axis0_TREADY,
  input  logic [DATA_WIDTH-1:0]     i_axis0_TDATA,
  input  logic                      i_axis0_TLAST,
  input  logic [DATA_WIDTH*2-1:0]   i_ethertype0,
  input  logic [DATA_WIDTH*6-1:0]   i_dst_mac0,
  input  logic                      i_axis1_TVALID,
  output logic                      o_axis1_TREADY,
  input  logic [DATA_WIDTH-1:0]     i_axis1_TDATA,
  input  logic                      i_axis1_TLAST,
  input  logic [DATA_WIDTH*2-1:0]   i_ethertype1,
  input  logic [DATA_WIDTH*6-1:0]   i_dst_mac1,
  output logic                      o_axis_TVALID,
  input  logic                      i_axis_TREADY,
  output logic [DATA_WIDTH-1:0]     o_axis_TDATA,
  output logic                      o_axis_TLAST,
  output logic [DATA_WIDTH*2-1:0]   o_ethertype,
  output logic [DATA_WIDTH*6-1:0]   o_dst_mac_addr,
  output logic [1:0]                o_grant,
  output logic                      o_abort
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  // Last requester served; reset to 1 so requester 0 wins the first tie.
  logic                      ptr_q, ptr_d;
  logic [DATA_WIDTH*2-1:0]   ethertype_q, ethertype_d;
  logic [DATA_WIDTH*6-1:0]   dst_mac_q, dst_mac_d;

  logic                      own_sel;
  logic                      own_valid;
  logic                      own_last;

`ifdef SAKEBI_TX_ARB_WATCHDOG_EN
  logic [7:0]                wd_q, wd_d;
  logic                      abort_q, abort_d;
`endif

  // Owner-side view of the requesters; only meaningful while granted.
  assign own_sel   = (state_q == GRANT1);
  assign own_valid = own_sel ? i_axis1_TVALID : i_axis0_TVALID;
  assign own_last  = own_sel ? i_axis1_TLAST  : i_axis0_TLAST;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    ethertype_d    = ethertype_q;
    dst_mac_d      = dst_mac_q;
    o_axis0_TREADY = 1'b0;
    o_axis1_TREADY = 1'b0;
    o_axis_TVALID  = 1'b0;
    o_axis_TDATA   = '0;
    o_axis_TLAST   = 1'b0;
    o_grant        = 2'b00;
`ifdef SAKEBI_TX_ARB_WATCHDOG_EN
    wd_d           = '0;
    abort_d        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Requester 0 wins when alone, or on a tie when requester 1 went last.
        if (i_axis0_TVALID && (!i_axis1_TVALID || ptr_q)) begin
          state_d     = GRANT0;
          ethertype_d = i_ethertype0;
          dst_mac_d   = i_dst_mac0;
        end else if (i_axis1_TVALID) begin
          state_d     = GRANT1;
          ethertype_d = i_ethertype1;
          dst_mac_d   = i_dst_mac1;
        end
      end

      GRANT0, GRANT1: begin
        o_grant        = own_sel ? 2'b10 : 2'b01;
        o_axis_TVALID  = own_valid;
        o_axis_TDATA   = own_sel ? i_axis1_TDATA : i_axis0_TDATA;
        o_axis_TLAST   = own_last;
        o_axis0_TREADY = !own_sel && i_axis_TREADY;
        o_axis1_TREADY =  own_sel && i_axis_TREADY;
        if (own_valid && i_axis_TREADY && own_last) begin
          state_d = IDLE;
          ptr_d   = own_sel;
        end
`ifdef SAKEBI_TX_ARB_WATCHDOG_EN
        // wd_q counts prior low cycles, so 254 here marks the 255th.
        else if (!own_valid) begin
          if (wd_q == 8'd254) begin
            state_d = IDLE;
            ptr_d   = own_sel;
            abort_d = 1'b1;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      ethertype_q <= '0;
      dst_mac_q   <= '0;
`ifdef SAKEBI_TX_ARB_WATCHDOG_EN
      wd_q        <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ethertype_q <= ethertype_d;
      dst_mac_q   <= dst_mac_d;
`ifdef SAKEBI_TX_ARB_WATCHDOG_EN
      wd_q        <= wd_d;
      abort_q     <= abort_d;
`endif
    end
  end

  assign o_ethertype    = ethertype_q;
  assign o_dst_mac_addr = dst_mac_q;

`ifdef SAKEBI_TX_ARB_WATCHDOG_EN
  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif

endmodule
